// File: rtl/dmem_dump.sv
// Streams a word range of data memory out on a valid/ready interface after a start pulse.
// Optional trailing checksum beat is enabled by defining DMEM_DUMP_CHECKSUM_EN.
module dmem_dump #(
    parameter int unsigned DMEM_SIZE_BYTES = 128,
    parameter int unsigned WORD_BYTES      = 4,
    parameter int unsigned ADDR_W          = $clog2(DMEM_SIZE_BYTES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              out_valid_o,
    output logic [31:0]       out_data_o,
    output logic              out_last_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CAPT,
        S_SEND,
`ifdef DMEM_DUMP_CHECKSUM_EN
        S_CSUM,
`endif
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef DMEM_DUMP_CHECKSUM_EN
    logic [31:0]       csum_q, csum_d;
`endif

    logic [ADDR_W-1:0] base_aligned;
    logic [ADDR_W-1:0] addr_next;
    logic              hs;

    assign base_aligned = {base_i[ADDR_W-1:2], 2'b00};
    // Natural overflow of the byte address gives the modulo-size wrap.
    assign addr_next    = ADDR_W'(addr_q + ADDR_W'(WORD_BYTES));
    assign hs           = out_valid_q & out_ready_i;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        mem_req_d   = 1'b0;
        mem_addr_d  = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef DMEM_DUMP_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d = base_aligned;
                    rem_d  = len_i;
`ifdef DMEM_DUMP_CHECKSUM_EN
                    csum_d = '0;
`endif
                    if (len_i == '0) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                        state_d     = S_CSUM;
                        out_valid_d = 1'b1;
                        out_data_d  = '0;
                        out_last_d  = 1'b1;
                        busy_d      = 1'b1;
`else
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
`endif
                    end else begin
                        state_d    = S_REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = base_aligned;
                        busy_d     = 1'b1;
                    end
                end
            end
            S_REQ: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                state_d     = S_SEND;
                out_valid_d = 1'b1;
                out_data_d  = mem_rdata_i;
`ifdef DMEM_DUMP_CHECKSUM_EN
                out_last_d  = 1'b0;
`else
                out_last_d  = (rem_q == LEN_W'(1));
`endif
            end
            S_SEND: begin
                if (hs) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    rem_d       = LEN_W'(rem_q - LEN_W'(1));
                    addr_d      = addr_next;
`ifdef DMEM_DUMP_CHECKSUM_EN
                    csum_d      = csum_q + out_data_q;
`endif
                    if (rem_q > LEN_W'(1)) begin
                        state_d    = S_REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = addr_next;
                    end else begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                        state_d     = S_CSUM;
                        out_valid_d = 1'b1;
                        out_data_d  = csum_q + out_data_q;
                        out_last_d  = 1'b1;
`else
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
`endif
                    end
                end
            end
`ifdef DMEM_DUMP_CHECKSUM_EN
            S_CSUM: begin
                if (hs) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = S_FIN;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                end
            end
`endif
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef DMEM_DUMP_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef DMEM_DUMP_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_dmem_dump.sv
// Directed bench for dmem_dump: table of dump vectors plus reset-mid-dump sequence.
module tb_dmem_dump;

    localparam int unsigned DMEM_SIZE_BYTES = 128;
    localparam int unsigned ADDR_W          = 7;
    localparam int unsigned NWORDS          = DMEM_SIZE_BYTES / 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_i;
    logic [ADDR_W-1:0] base_i;
    logic [ADDR_W:0]   len_i;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_rdata_i = '0;
    logic              out_valid_o;
    logic [31:0]       out_data_o;
    logic              out_last_o;
    logic              out_ready_i = 1'b1;
    logic              busy_o;
    logic              done_o;

    dmem_dump #(.DMEM_SIZE_BYTES(DMEM_SIZE_BYTES), .WORD_BYTES(4), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .base_i     (base_i),
        .len_i      (len_i),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_rdata_i(mem_rdata_i),
        .out_valid_o(out_valid_o),
        .out_data_o (out_data_o),
        .out_last_o (out_last_o),
        .out_ready_i(out_ready_i),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read data memory model
    logic [31:0] mem [NWORDS];
    always @(posedge clk) if (mem_req_o) mem_rdata_i <= mem[mem_addr_o[ADDR_W-1:2]];

    int checks = 0;
    int errors = 0;

    logic [31:0]       beat_data [$];
    logic              beat_last [$];
    logic [ADDR_W-1:0] req_addr  [$];
    int   done_cnt, done_cyc, first_valid_cyc, busy_seen;
    int   rmode = 0;
    bit   chk_en = 1'b0;
    logic prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
    logic [31:0] prev_data = '0;
    logic [15:0] bp_pat = 16'b1001_0110_0010_1001;

    // Monitor: samples on the falling edge, then drives ready for the next rising edge
    always @(negedge clk) begin
        if (chk_en && prev_valid && !prev_ready) begin
            checks++;
            if (!out_valid_o || out_data_o !== prev_data || out_last_o !== prev_last) begin
                errors++;
                $display("FAIL stable: valid=%0b data=%h last=%0b required valid=1 data=%h last=%0b",
                         out_valid_o, out_data_o, out_last_o, prev_data, prev_last);
            end
        end
        if (chk_en && mem_req_o) begin
            req_addr.push_back(mem_addr_o);
            checks++;
            if (out_valid_o) begin
                errors++;
                $display("FAIL req_overlap: valid=%0b during mem_req, required 0", out_valid_o);
            end
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy_o) busy_seen = 1;
        if (out_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        case (rmode)
            0:       out_ready_i = 1'b1;
            1:       out_ready_i = bp_pat[cyc % 16];
            default: out_ready_i = 1'b0;
        endcase
        if (out_valid_o && out_ready_i) begin
            beat_data.push_back(out_data_o);
            beat_last.push_back(out_last_o);
        end
        prev_valid = out_valid_o;
        prev_ready = out_ready_i;
        prev_data  = out_data_o;
        prev_last  = out_last_o;
    end

    typedef struct {
        logic [ADDR_W-1:0]      base;
        logic [ADDR_W:0]        len;
        int                     rmode;
        bit                     mid_start;
        logic [3:0][ADDR_W-1:0] addr;
        logic [3:0][31:0]       data;
        logic [31:0]            csum;
    } vec_t;

    vec_t vecs [5];

    function automatic vec_t mk(input int b, input int l, input int rm, input bit ms,
                                input int a0, input int a1, input int a2, input int a3,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [31:0] cs);
        vec_t v;
        v.base = ADDR_W'(b);
        v.len  = (ADDR_W+1)'(l);
        v.rmode = rm;
        v.mid_start = ms;
        v.addr[0] = ADDR_W'(a0); v.addr[1] = ADDR_W'(a1);
        v.addr[2] = ADDR_W'(a2); v.addr[3] = ADDR_W'(a3);
        v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
        v.csum = cs;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        beat_data.delete();
        beat_last.delete();
        req_addr.delete();
        done_cnt = 0;
        done_cyc = -1;
        first_valid_cyc = -1;
        busy_seen = 0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int start_cyc;
        int n;
        int nb;
        int l;
        l = int'(v.len);
        clear_logs();
        rmode = v.rmode;
        step();
        base_i = v.base; len_i = v.len; start_i = 1'b1;
        start_cyc = cyc;
        step();
        start_i = 1'b0;
        if (v.mid_start) begin
            step();
            base_i = '0; len_i = (ADDR_W+1)'(3); start_i = 1'b1;
            step();
            start_i = 1'b0;
        end
        n = 0;
        while (done_cnt == 0 && n < 300) begin
            step();
            n++;
        end
        if (done_cnt == 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no done_o after %0d cycles, required done", tag, n);
        end
        repeat (6) step();
`ifdef DMEM_DUMP_CHECKSUM_EN
        nb = l + 1;
`else
        nb = l;
`endif
        chk({tag, "_beats"}, beat_data.size(), nb);
        for (int i = 0; i < l && i < beat_data.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), beat_data[i], v.data[i]);
`ifdef DMEM_DUMP_CHECKSUM_EN
            chk($sformatf("%s_last%0d", tag, i), 32'(beat_last[i]), 32'd0);
`else
            chk($sformatf("%s_last%0d", tag, i), 32'(beat_last[i]), 32'(i == l - 1));
`endif
        end
`ifdef DMEM_DUMP_CHECKSUM_EN
        if (beat_data.size() > l) begin
            chk({tag, "_csum"}, beat_data[l], v.csum);
            chk({tag, "_csum_last"}, 32'(beat_last[l]), 32'd1);
        end
`endif
        chk({tag, "_nreq"}, req_addr.size(), l);
        for (int i = 0; i < l && i < req_addr.size(); i++)
            chk($sformatf("%s_addr%0d", tag, i), 32'(req_addr[i]), 32'(v.addr[i]));
        chk({tag, "_done_cnt"}, done_cnt, 1);
        if (l > 0) begin
            chk({tag, "_latency"}, first_valid_cyc - start_cyc, 3);
        end else begin
`ifndef DMEM_DUMP_CHECKSUM_EN
            chk({tag, "_done_lat"}, done_cyc - start_cyc, 1);
            chk({tag, "_busy_seen"}, busy_seen, 0);
            chk({tag, "_no_valid"}, first_valid_cyc, -1);
`endif
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; start_i = 1'b0; base_i = '0; len_i = '0;
        for (int i = 0; i < NWORDS; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222;
        mem[2] = 32'h3333_3333; mem[3] = 32'h4444_4444;

        vecs[0] = mk(0,   4, 0, 0, 0,   4,   8, 12,
                     32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'hAAAAAAAA);
        vecs[1] = mk(0,   4, 1, 0, 0,   4,   8, 12,
                     32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'hAAAAAAAA);
        vecs[2] = mk(120, 4, 0, 0, 120, 124, 0, 4,
                     32'hA000001E, 32'hA000001F, 32'h11111111, 32'h22222222, 32'h7333336F);
        vecs[3] = mk(11,  1, 0, 1, 8,   0,   0, 0,
                     32'h33333333, 32'h0, 32'h0, 32'h0, 32'h33333333);
        vecs[4] = mk(0,   0, 0, 0, 0,   0,   0, 0,
                     32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

        repeat (3) step();
        chk("rst_req",   32'(mem_req_o),   32'd0);
        chk("rst_addr",  32'(mem_addr_o),  32'd0);
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_data",  out_data_o,       32'd0);
        chk("rst_last",  32'(out_last_o),  32'd0);
        chk("rst_busy",  32'(busy_o),      32'd0);
        chk("rst_done",  32'(done_o),      32'd0);
        reset = 1'b0;
        step();
        chk_en = 1'b1;

        for (int k = 0; k < 5; k++) run_vec(vecs[k], $sformatf("v%0d", k));

        // Reset while a beat is held with ready low
        chk_en = 1'b0;
        clear_logs();
        rmode = 2;
        step();
        base_i = '0; len_i = (ADDR_W+1)'(4); start_i = 1'b1;
        step();
        start_i = 1'b0;
        n = 0;
        while (!out_valid_o && n < 20) begin
            step();
            n++;
        end
        chk("mid_valid_reached", 32'(out_valid_o), 32'd1);
        step();
        reset = 1'b1;
        step();
        chk("mid_rst_req",   32'(mem_req_o),   32'd0);
        chk("mid_rst_addr",  32'(mem_addr_o),  32'd0);
        chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
        chk("mid_rst_data",  out_data_o,       32'd0);
        chk("mid_rst_last",  32'(out_last_o),  32'd0);
        chk("mid_rst_busy",  32'(busy_o),      32'd0);
        chk("mid_rst_done",  32'(done_o),      32'd0);
        reset = 1'b0;
        rmode = 0;
        repeat (5) step();
        chk("mid_rst_no_done",  done_cnt, 0);
        chk("mid_rst_no_beats", beat_data.size(), 0);
        chk_en = 1'b1;
        run_vec(vecs[0], "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_dump.md
Name: dmem_dump

Overview:
- Read-out counterpart to the memory-image loader used by the processor bench.
- After a program runs, the bench pulses start; the block walks a word range of data memory through a synchronous read port.
- Each word is streamed out on a valid/ready interface, so the bench can compare memory contents against a golden file.
- Sits beside `proc` and shares the dmem read port with it, under bench control.

Parameters:
- DMEM_SIZE_BYTES, 128, data memory size in bytes; power of two, at least 8.
- WORD_BYTES, 4, bytes per word; fixed at 4 (32-bit words).
- ADDR_W, $clog2(DMEM_SIZE_BYTES), byte-address width.

Ports:
- clk  in  1  core clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle request to begin a dump; ignored while busy_o=1.
- base_i  in  ADDR_W  start byte address; sampled on accepted start; bits [1:0] forced to 0.
- len_i  in  ADDR_W+1  number of words to dump; sampled on accepted start.
- mem_req_o  out  1  read strobe to dmem.
- mem_addr_o  out  ADDR_W  word-aligned byte address for the read.
- mem_rdata_i  in  32  read data; valid exactly one cycle after mem_req_o.
- out_valid_o  out  1  stream word valid.
- out_data_o  out  32  stream word.
- out_last_o  out  1  marks the final beat of a dump.
- out_ready_i  in  1  stream consumer ready.
- busy_o  out  1  high from the cycle after an accepted start until the cycle done_o pulses.
- done_o  out  1  one-cycle pulse when a dump completes.

Behaviour:
- Reset (reset=1 at a clk edge):
  - state=IDLE.
  - All outputs 0: mem_req_o, mem_addr_o, out_valid_o, out_data_o, out_last_o, busy_o, done_o.
  - Internal counters 0.
  - Reset wins over every other event, including mid-dump; a partial dump is abandoned with no done_o.
- States: IDLE, REQ, CAPT, SEND, FIN.
- IDLE:
  - start_i=1 latches addr=base_i&~3 and remaining=len_i.
  - If len_i=0, go to FIN.
  - Otherwise go to REQ; busy_o=1 from the next cycle.
- REQ:
  - mem_req_o=1 and mem_addr_o=addr for exactly one cycle.
  - Next state CAPT.
- CAPT:
  - Register mem_rdata_i into out_data_o.
  - out_valid_o=1 from the next cycle.
  - out_last_o=1 if remaining==1.
  - Next state SEND.
- SEND:
  - Hold out_valid_o, out_data_o and out_last_o stable until out_valid_o & out_ready_i.
  - On handshake, drop out_valid_o and decrement remaining.
  - Advance addr by 4, wrapping modulo DMEM_SIZE_BYTES (e.g. 124 → 0 when the size is 128).
  - Next state REQ if remaining>1 before the decrement, else FIN.
- FIN:
  - done_o=1 for one cycle, busy_o=0 in the same cycle.
  - Return to IDLE; a start_i in the FIN cycle is ignored.
- Latency and throughput:
  - start to first out_valid_o: 3 cycles (IDLE→REQ→CAPT→valid).
  - With out_ready_i held at 1, one word every 3 cycles.
- Stream rules:
  - out_valid_o never deasserts without a handshake.
  - out_ready_i may be asserted before out_valid_o.
  - mem_req_o is never asserted outside REQ.
- len_i greater than the memory size in words is legal: the address wraps and words repeat.

Optional Feature:
- Macro: DMEM_DUMP_CHECKSUM_EN.
- Defined:
  - A 32-bit accumulator, cleared on accepted start, adds each data word modulo 2^32 at its handshake.
  - After the last data word, the block emits one extra beat with out_data_o = checksum and out_last_o=1; the preceding data beat has out_last_o=0.
  - The FSM adds state CSUM between SEND and FIN.
  - For len_i=0, exactly one beat with value 0 is emitted before done_o.
- Not defined:
  - No accumulator and no CSUM state.
  - out_last_o sits on the final data word.
  - len_i=0 produces no beats.

Test Plan:
- Preload dmem words 0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444; start base=0, len=4, ready tied 1.
  - Expect 4 beats in order, last only on 0x44444444, first valid 3 cycles after start, done_o once.
  - With CHECKSUM_EN: a 5th beat 0xAAAAAAAA with last.
- Backpressure: same image, out_ready_i toggled 1-0-0-1 pseudo-randomly.
  - Data and last stay stable while valid=1 and ready=0.
  - Each mem_req_o is issued only after the previous handshake.
  - Beat count and order unchanged.
- Wrap: DMEM_SIZE_BYTES=128, base=120, len=4.
  - mem_addr_o sequence 120, 124, 0, 4.
- len=0:
  - done_o one cycle after start, no out_valid_o, busy_o never high.
  - With CHECKSUM_EN: one beat 0x00000000 with last.
- Unaligned base=0x0B, len=1:
  - mem_addr_o=0x08, one beat with last.
  - A start_i pulse mid-dump is ignored (no restart, no extra beats).
- Reset asserted while in SEND with out_valid_o=1:
  - Next cycle all outputs are 0 and the state is IDLE.
  - No done_o.
  - A subsequent start performs a clean full dump.
